// File: rtl/cepstral_mac.sv
// cepstral_mac: DCT multiply-accumulate engine for the MFCC cepstral stage.
// Buffers one frame of NFILT log mel energies. For each k in 0..NCEP-1 it forms
// sum_n buf[n] * coef[k*NFILT+n] against an external ROM (1-cycle read latency),
// then rounds (half-up), shifts right by SHIFT and saturates to OW bits.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_start     synchronous abort/restart into LOAD
//   in_valid/in_ready/in_data          energy input handshake
//   coef_rd_en/coef_rd_addr/coef_data  coefficient ROM read port
//   out_valid/out_ready/out_data/out_idx/out_last  coefficient output handshake
module cepstral_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 8,
  parameter int unsigned NFILT = 26,
  parameter int unsigned NCEP  = 13,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 7,
  localparam int unsigned AW   = $clog2(NFILT * NCEP),
  localparam int unsigned KW   = (NCEP > 1) ? $clog2(NCEP) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          coef_rd_en,
  output logic [AW-1:0] coef_rd_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [KW-1:0] out_idx,
  output logic          out_last
);

  localparam int unsigned ACCW = DW + CW + $clog2(NFILT);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned WW   = (NFILT > 1) ? $clog2(NFILT) : 1;
  localparam int unsigned NW   = $clog2(NFILT + 2);
  // 2^(SHIFT-1) for SHIFT>0, zero for SHIFT=0
  localparam logic [ACCW:0] BIAS = ((ACCW + 1)'(1) << SHIFT) >> 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StMac  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   opnd_q, opnd_d;
  logic            v1_q, v1_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            v2_q, v2_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]   buf_q [NFILT];
  logic            buf_we;

  logic            issue;
  logic [PW-1:0]   mult;
  logic [ACCW:0]   biased;
  logic signed [ACCW:0] shifted;
  logic [OW-1:0]   sat;

  // Issue phase covers n = 0..NFILT-1; n = NFILT, NFILT+1 are pipeline drain.
  assign issue = (state_q == StMac) && (n_q < NW'(NFILT));

  // Operands sign-extended to PW so the truncated product is the signed product.
  assign mult = {{CW{opnd_q[DW-1]}}, opnd_q} * {{DW{coef_data[CW-1]}}, coef_data};

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    n_d      = n_q;
    k_d      = k_q;
    addr_d   = addr_q;
    opnd_d   = opnd_q;
    v1_d     = 1'b0;
    prod_d   = prod_q;
    v2_d     = v1_q;
    acc_d    = acc_q;
    buf_we   = 1'b0;

    // Stage 1: fetch buffer operand alongside the ROM address.
    if (issue) begin
      opnd_d = buf_q[n_q[WW-1:0]];
      v1_d   = 1'b1;
      addr_d = addr_q + AW'(1);
    end
    // Stage 2: ROM data has arrived; form the product.
    if (v1_q) begin
      if ((opnd_q == '0) || (coef_data == '0)) prod_d = '0;
      else                                       prod_d = mult;
    end
    // Stage 3: accumulate.
    if (v2_q) acc_d = acc_q + {{(ACCW - PW){prod_q[PW-1]}}, prod_q};

    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (wr_cnt_q == WW'(NFILT - 1)) begin
            wr_cnt_d = '0;
            k_d      = '0;
            n_d      = '0;
            addr_d   = '0;
            acc_d    = '0;
            state_d  = StMac;
          end else begin
            wr_cnt_d = wr_cnt_q + WW'(1);
          end
        end
      end
      StMac: begin
        if (n_q == NW'(NFILT + 1)) begin
          n_d     = '0;
          state_d = StOut;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      StOut: begin
        if (out_ready) begin
          if (k_q == KW'(NCEP - 1)) begin
            k_d     = '0;
            addr_d  = '0;
            state_d = StLoad;
          end else begin
            // addr_q already sits at (k+1)*NFILT after the previous row.
            k_d     = k_q + KW'(1);
            n_d     = '0;
            acc_d   = '0;
            state_d = StMac;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      state_d  = StLoad;
      wr_cnt_d = '0;
      k_d      = '0;
      n_d      = '0;
      addr_d   = '0;
      acc_d    = '0;
      v1_d     = 1'b0;
      v2_d     = 1'b0;
      buf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_cnt_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      opnd_q   <= '0;
      v1_q     <= 1'b0;
      prod_q   <= '0;
      v2_q     <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      n_q      <= n_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      opnd_q   <= opnd_d;
      v1_q     <= v1_d;
      prod_q   <= prod_d;
      v2_q     <= v2_d;
      acc_q    <= acc_d;
    end
  end

  // Energy buffer: no reset, every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_cnt_q] <= in_data;
  end

  // Round half-up, arithmetic shift, then clamp to the OW-bit signed range.
  always_comb begin
    biased  = {acc_q[ACCW-1], acc_q} + BIAS;
    shifted = $signed(biased) >>> SHIFT;
    if ((&shifted[ACCW:OW-1]) || (~|shifted[ACCW:OW-1])) sat = shifted[OW-1:0];
    else if (shifted[ACCW])                               sat = {1'b1, {(OW - 1){1'b0}}};
    else                                                  sat = {1'b0, {(OW - 1){1'b1}}};
  end

  assign in_ready     = (state_q == StLoad);
  assign coef_rd_en   = issue;
  assign coef_rd_addr = issue ? addr_q : '0;
  assign out_valid    = (state_q == StOut);
  assign out_data     = out_valid ? sat : '0;
  assign out_idx      = out_valid ? k_q : '0;
  assign out_last     = out_valid && (k_q == KW'(NCEP - 1));

endmodule
